// File: rtl/game_ctrl_pkg.sv
// Shared phase encoding, field widths and tick arithmetic for the round controller.
// Optional feature: GAME_ROUND_CONTROLLER_HIGH_SCORE_EN (see game_round_controller).
package game_ctrl_pkg;

    localparam int LEVEL_W = 3;
    localparam int LIVES_W = 2;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        PLAY  = 3'd2,
        WIN   = 3'd3,
        LOSS  = 3'd4,
        OVER  = 3'd5
    } phase_t;

    function automatic int sub_cycles(input int clk_mhz, input int tick_hz);
        int s;
        s = (clk_mhz * 1000000) / (tick_hz * 8);
        return (s < 1) ? 1 : s;
    endfunction

endpackage

// File: rtl/game_tick_prescaler.sv
// Subtick / base_tick generator with a level-dependent divider gating game_tick.
// clear realigns all counters so the first game_tick lands a fixed time after round_start.
module game_tick_prescaler
    import game_ctrl_pkg::*;
#(
    parameter int SUB = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               play,
    input  logic [LEVEL_W-1:0] level,
    output logic               game_tick,
    output logic               base_tick
);

    localparam int SW = (SUB > 1) ? $clog2(SUB) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(SUB - 1);

    logic [SW-1:0] sub_cnt;
    logic [2:0]    div_cnt;
    logic [2:0]    base_cnt;
    logic [2:0]    div_last;
    logic          subtick;
    logic          div_wrap;

    assign subtick   = (sub_cnt == SUB_LAST);
    assign div_last  = 3'd7 - level;
    // >= keeps the divider bounded if level rises between rounds
    assign div_wrap  = (div_cnt >= div_last);
    assign game_tick = play & subtick & div_wrap;
    assign base_tick = subtick & (base_cnt == 3'd7);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sub_cnt  <= '0;
            div_cnt  <= '0;
            base_cnt <= '0;
        end else if (clear) begin
            sub_cnt  <= '0;
            div_cnt  <= '0;
            base_cnt <= '0;
        end else if (subtick) begin
            sub_cnt  <= '0;
            div_cnt  <= div_wrap ? 3'd0 : div_cnt + 3'd1;
            base_cnt <= base_cnt + 3'd1;
        end else begin
            sub_cnt  <= sub_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer for the LCD shooter: start sync, round FSM, score/lives/level.
// Define GAME_ROUND_CONTROLLER_HIGH_SCORE_EN to keep a best-score register.
module game_round_controller
    import game_ctrl_pkg::*;
#(
    parameter int CLK_MHZ          = 27,
    parameter int TICK_HZ_BASE     = 50,
    parameter int LIVES            = 3,
    parameter int ROUNDS_PER_LEVEL = 4,
    parameter int RESULT_TICKS     = 100,
    parameter int W_SCORE          = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start_key,
    input  logic               round_won,
    input  logic               round_lost,
    output logic               game_tick,
    output logic               round_start,
    output logic [2:0]         phase,
    output logic [LEVEL_W-1:0] level,
    output logic [LIVES_W-1:0] lives,
    output logic [W_SCORE-1:0] score,
    output logic               game_over,
    output logic [W_SCORE-1:0] high_score
);

    localparam int SUB     = sub_cycles(CLK_MHZ, TICK_HZ_BASE);
    localparam int RT_INIT = (RESULT_TICKS < 1) ? 1 : RESULT_TICKS;
    localparam int RT_W    = $clog2(RT_INIT + 1);
    localparam int WC_W    = $clog2(ROUNDS_PER_LEVEL + 1);
    localparam int SUM_W   = W_SCORE + 1;

    phase_t            state;
    logic              key_s1, key_s2, key_s3, start_edge;
    logic [WC_W-1:0]   won_cnt, won_inc;
    logic [RT_W-1:0]   timer;
    logic              base_tick;
    logic              level_up;
    logic              result_done;
    logic              enter_over;
    logic [SUM_W-1:0]  score_sum;
    logic [W_SCORE-1:0] score_win;

    assign phase       = state;
    assign won_inc     = won_cnt + WC_W'(1);
    assign level_up    = (won_inc == WC_W'(ROUNDS_PER_LEVEL));
    assign result_done = base_tick && (timer == RT_W'(1));
    assign enter_over  = (state == LOSS) && result_done && (lives == '0);
    assign score_sum   = {1'b0, score} + SUM_W'(level) + SUM_W'(1);
    assign score_win   = score_sum[W_SCORE] ? '1 : score_sum[W_SCORE-1:0];

    // start_edge is registered: the press reaches the FSM 3 cycles after the pin
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_s1     <= 1'b0;
            key_s2     <= 1'b0;
            key_s3     <= 1'b0;
            start_edge <= 1'b0;
        end else begin
            key_s1     <= start_key;
            key_s2     <= key_s1;
            key_s3     <= key_s2;
            start_edge <= key_s2 & ~key_s3;
        end
    end

    game_tick_prescaler #(
        .SUB(SUB)
    ) u_prescaler (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (round_start),
        .play      (state == PLAY),
        .level     (level),
        .game_tick (game_tick),
        .base_tick (base_tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            round_start <= 1'b0;
            game_over   <= 1'b0;
            level       <= '0;
            lives       <= '0;
            score       <= '0;
            won_cnt     <= '0;
            timer       <= '0;
        end else begin
            round_start <= 1'b0;
            unique case (state)
                IDLE, OVER: begin
                    if (start_edge) begin
                        score       <= '0;
                        lives       <= LIVES_W'(LIVES);
                        level       <= '0;
                        won_cnt     <= '0;
                        game_over   <= 1'b0;
                        round_start <= 1'b1;
                        state       <= ARMED;
                    end
                end
                ARMED: state <= PLAY;
                PLAY: begin
                    if (round_lost) begin
                        if (lives != '0) lives <= lives - LIVES_W'(1);
                        timer <= RT_W'(RT_INIT);
                        state <= LOSS;
                    end else if (round_won) begin
                        score   <= score_win;
                        won_cnt <= level_up ? '0 : won_inc;
                        if (level_up && level != LEVEL_MAX)
                            level <= level + LEVEL_W'(1);
                        timer <= RT_W'(RT_INIT);
                        state <= WIN;
                    end
                end
                WIN, LOSS: begin
                    if (base_tick) timer <= timer - RT_W'(1);
                    if (enter_over) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (result_done) begin
                        round_start <= 1'b1;
                        state       <= ARMED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GAME_ROUND_CONTROLLER_HIGH_SCORE_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            high_score <= '0;
        else if (enter_over && score > high_score)
            high_score <= score;
    end
`else
    assign high_score = '0;
`endif

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller: directed table + randomized play vs a reference model.
// A second instance with a 4-bit score exercises score saturation.
module tb_game_round_controller;
    import game_ctrl_pkg::*;

    localparam int SUB    = 4;
    localparam int RT     = 2;
    localparam int RPL    = 4;
    localparam int NL     = 3;
    localparam int SMAX   = 65535;
    localparam int SMAX_S = 15;
`ifdef GAME_ROUND_CONTROLLER_HIGH_SCORE_EN
    localparam int HS_AFTER = 6;
`else
    localparam int HS_AFTER = 0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_key = 1'b0;
    logic        round_won = 1'b0;
    logic        round_lost = 1'b0;

    logic        game_tick, round_start, game_over;
    logic [2:0]  phase, level;
    logic [1:0]  lives;
    logic [15:0] score, high_score;

    logic        game_tick_s, round_start_s, game_over_s;
    logic [2:0]  phase_s, level_s;
    logic [1:0]  lives_s;
    logic [3:0]  score_s, high_score_s;

    always #5 clock = ~clock;

    game_round_controller #(
        .CLK_MHZ(1), .TICK_HZ_BASE(31250), .LIVES(NL),
        .ROUNDS_PER_LEVEL(RPL), .RESULT_TICKS(RT), .W_SCORE(16)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start_key(start_key),
        .round_won(round_won), .round_lost(round_lost),
        .game_tick(game_tick), .round_start(round_start), .phase(phase),
        .level(level), .lives(lives), .score(score),
        .game_over(game_over), .high_score(high_score)
    );

    game_round_controller #(
        .CLK_MHZ(1), .TICK_HZ_BASE(31250), .LIVES(NL),
        .ROUNDS_PER_LEVEL(RPL), .RESULT_TICKS(RT), .W_SCORE(4)
    ) dut_s (
        .clock(clock), .reset_n(reset_n), .start_key(start_key),
        .round_won(round_won), .round_lost(round_lost),
        .game_tick(game_tick_s), .round_start(round_start_s), .phase(phase_s),
        .level(level_s), .lives(lives_s), .score(score_s),
        .game_over(game_over_s), .high_score(high_score_s)
    );

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference model: game rules at round level; tick timing from
    // "cycles since round_start" arithmetic rather than counters.
    int     cyc = 0;
    int     press_q[$];
    int     kc;
    phase_t m_ph, m_nx;
    int     m_score, m_score_s, m_lives, m_level, m_won, m_tmr;
    int     m_hs, m_hs_s;
    bit     m_go, m_rs, m_press, m_base;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_ph = IDLE; m_score = 0; m_score_s = 0; m_lives = 0;
            m_level = 0; m_won = 0; m_tmr = 0; m_go = 0; m_rs = 0;
            m_hs = 0; m_hs_s = 0; kc = 0;
            press_q.delete();
        end else begin
            cyc++;
            m_press = 0;
            while (press_q.size() > 0 && press_q[0] <= cyc) begin
                if (press_q[0] == cyc) m_press = 1;
                void'(press_q.pop_front());
            end
            m_base = (kc > 0) && (kc % (8 * SUB) == 0);
            m_nx = m_ph;
            case (m_ph)
                IDLE, OVER: if (m_press) begin
                    m_score = 0; m_score_s = 0; m_lives = NL;
                    m_level = 0; m_won = 0; m_go = 0; m_nx = ARMED;
                end
                ARMED: m_nx = PLAY;
                PLAY: if (round_lost) begin
                    if (m_lives > 0) m_lives--;
                    m_tmr = RT; m_nx = LOSS;
                end else if (round_won) begin
                    m_score   = imin(m_score + m_level + 1, SMAX);
                    m_score_s = imin(m_score_s + m_level + 1, SMAX_S);
                    m_won++;
                    if (m_won == RPL) begin
                        m_won = 0;
                        if (m_level < 7) m_level++;
                    end
                    m_tmr = RT; m_nx = WIN;
                end
                WIN, LOSS: if (m_base) begin
                    m_tmr--;
                    if (m_tmr == 0) begin
                        if (m_ph == LOSS && m_lives == 0) begin
                            m_nx = OVER; m_go = 1;
`ifdef GAME_ROUND_CONTROLLER_HIGH_SCORE_EN
                            if (m_score > m_hs) m_hs = m_score;
                            if (m_score_s > m_hs_s) m_hs_s = m_score_s;
`endif
                        end else m_nx = ARMED;
                    end
                end
                default: ;
            endcase
            m_rs = (m_nx == ARMED);
            kc = (m_nx == ARMED) ? 0 : kc + 1;
            m_ph = m_nx;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            int per;
            bit etick;
            per = (8 - m_level) * SUB;
            etick = (m_ph == PLAY) && (kc > 0) && (kc % per == 0);
            check("phase", int'(phase), int'(m_ph));
            check("game_tick", int'(game_tick), int'(etick));
            check("round_start", int'(round_start), int'(m_rs));
            check("level", int'(level), m_level);
            check("lives", int'(lives), m_lives);
            check("score", int'(score), m_score);
            check("game_over", int'(game_over), int'(m_go));
            check("high_score", int'(high_score), m_hs);
            check("s_phase", int'(phase_s), int'(m_ph));
            check("s_game_tick", int'(game_tick_s), int'(etick));
            check("s_round_start", int'(round_start_s), int'(m_rs));
            check("s_level", int'(level_s), m_level);
            check("s_lives", int'(lives_s), m_lives);
            check("s_game_over", int'(game_over_s), int'(m_go));
            check("s_score", int'(score_s), m_score_s);
            check("s_high_score", int'(high_score_s), m_hs_s);
        end
    end

    task automatic press();
        start_key = 1'b1;
        press_q.push_back(cyc + 4);
        repeat (2) @(negedge clock);
        start_key = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_phase(input phase_t p, input int budget);
        int n;
        n = 0;
        while (phase != p && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("wait_phase", int'(phase), int'(p));
    endtask

    task automatic count_to_tick(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!game_tick && n < 200);
    endtask

    typedef struct {
        bit     won;
        bit     lost;
        phase_t ph_hit;
        int     score;
        int     lives;
        int     level;
        phase_t ph_end;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n, first, n_rs;
        tbl[0] = '{1'b1, 1'b0, WIN,  1, 3, 0, ARMED};
        tbl[1] = '{1'b1, 1'b0, WIN,  2, 3, 0, ARMED};
        tbl[2] = '{1'b1, 1'b0, WIN,  3, 3, 0, ARMED};
        tbl[3] = '{1'b1, 1'b0, WIN,  4, 3, 1, ARMED};
        tbl[4] = '{1'b1, 1'b0, WIN,  6, 3, 1, ARMED};
        tbl[5] = '{1'b1, 1'b1, LOSS, 6, 2, 1, ARMED};
        tbl[6] = '{1'b0, 1'b1, LOSS, 6, 1, 1, ARMED};
        tbl[7] = '{1'b0, 1'b1, LOSS, 6, 0, 1, OVER};

        repeat (3) @(negedge clock);
        check("rst_phase", int'(phase), 0);
        check("rst_lives", int'(lives), 0);
        check("rst_score", int'(score), 0);
        check("rst_round_start", int'(round_start), 0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        @(negedge clock);
        round_won = 1'b1;
        @(negedge clock);
        round_won = 1'b0;
        @(negedge clock);
        check("idle_spurious_won", int'(phase), int'(IDLE));

        // start press: round_start once, 4 cycles after the pin; won in ARMED ignored
        start_key = 1'b1;
        press_q.push_back(cyc + 4);
        n_rs = 0;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (i == 2) start_key = 1'b0;
            if (round_start) begin
                n_rs++;
                if (first < 0) first = i;
            end
            if (i == 4) round_won = 1'b1;
            if (i == 5) begin
                round_won = 1'b0;
                check("start_phase_play", int'(phase), int'(PLAY));
                check("start_lives", int'(lives), 3);
                check("start_score", int'(score), 0);
            end
        end
        check("start_latency", first, 4);
        check("start_pulses", n_rs, 1);

        count_to_tick(n);
        count_to_tick(n);
        check("period_lvl0", n, 32);

        foreach (tbl[i]) begin
            wait_phase(PLAY, 300);
            repeat ($urandom_range(0, 3)) @(negedge clock);
            round_won  = tbl[i].won;
            round_lost = tbl[i].lost;
            @(negedge clock);
            round_won  = 1'b0;
            round_lost = 1'b0;
            check("tbl_phase_hit", int'(phase), int'(tbl[i].ph_hit));
            check("tbl_score", int'(score), tbl[i].score);
            check("tbl_lives", int'(lives), tbl[i].lives);
            check("tbl_level", int'(level), tbl[i].level);
            wait_phase(tbl[i].ph_end, 300);
            check("tbl_round_start", int'(round_start), int'(tbl[i].ph_end == ARMED));
            check("tbl_game_over", int'(game_over), int'(tbl[i].ph_end == OVER));
        end
        check("hs_at_over", int'(high_score), HS_AFTER);

        press();
        check("restart_armed", int'(phase), int'(ARMED));
        count_to_tick(n);
        check("latency_lvl0", n, 32);
        check("hs_after_restart", int'(high_score), HS_AFTER);
        check("restart_score", int'(score), 0);

        for (int w = 0; w < 20; w++) begin
            wait_phase(PLAY, 100);
            round_won = 1'b1;
            @(negedge clock);
            round_won = 1'b0;
            wait_phase(ARMED, 200);
        end
        check("lvl5_level", int'(level), 5);
        check("lvl5_score", int'(score), 60);
        check("sat_score_s", int'(score_s), 15);
        count_to_tick(n);
        check("latency_lvl5", n, 12);
        count_to_tick(n);
        check("period_lvl5", n, 12);

        // async reset between clock edges must clear outputs immediately
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_phase", int'(phase), 0);
        check("arst_score", int'(score), 0);
        check("arst_level", int'(level), 0);
        check("arst_lives", int'(lives), 0);
        check("arst_tick", int'(game_tick), 0);
        check("arst_high_score", int'(high_score), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        for (int it = 0; it < 5000; it++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 30) begin
                press();
            end else if (r < 2) begin
                @(negedge clock);
            end else if (r < 140) begin
                round_won = 1'b1;
                @(negedge clock);
                round_won = 1'b0;
            end else if (r < 220) begin
                round_lost = 1'b1;
                @(negedge clock);
                round_lost = 1'b0;
            end else if (r < 245) begin
                round_won = 1'b1;
                round_lost = 1'b1;
                @(negedge clock);
                round_won = 1'b0;
                round_lost = 1'b0;
            end else if (r < 247) begin
                @(posedge clock);
                #2 reset_n = 1'b0;
                repeat (2) @(negedge clock);
                reset_n = 1'b1;
            end else begin
                @(negedge clock);
            end
        end

        repeat (4) @(negedge clock);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
